// File: rtl/fetch_sequencer.sv
// Redux-V fetch sequencer: fetches 8-bit instructions, splits fields, picks next PC.
// Optional halt-on-jump-to-self: define FETCH_SEQUENCER_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [7:0]      imem_data,
  output logic [3:0]      opcode,
  output logic [1:0]      ra,
  output logic [1:0]      rb,
  output logic [3:0]      imm,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            b_mx,
  input  logic            j_mx,
  input  logic            reg_zero,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_sext;
  logic [7:0]      r_ir;
  logic [7:0]      w_next_ir;
  logic            r_req;
  logic            w_next_req;
  logic            w_jump;

  assign w_sext = {{(PC_W-4){r_ir[3]}}, r_ir[3:0]};
  // A failed conditional branch never falls through to the jump path
  assign w_jump = !b_mx && j_mx;

  // Next-PC select: taken branch, then relative jump, then sequential
  always_comb begin
    w_target = r_pc + ONE;
    if (b_mx) begin
      if (reg_zero) w_target = branch_target;
    end else if (j_mx) begin
      w_target = r_pc + w_sext;
    end
  end

  // State, PC, IR and request register update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= 8'h00;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ir    <= w_next_ir;
      r_req   <= w_next_req;
    end
  end

  // Next-state logic; imem_valid only counts while a request is out
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ir    = r_ir;
    w_next_req   = r_req;
    unique case (r_state)
      S_FETCH: begin
        w_next_req = 1'b1;
        if (r_req && imem_valid) begin
          w_next_ir    = imem_data;
          w_next_req   = 1'b0;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_req = 1'b0;
        if (!stall) begin
          w_next_pc    = w_target;
          w_next_req   = 1'b1;
          w_next_state = S_FETCH;
`ifdef FETCH_SEQUENCER_HALT_DETECT_EN
          if (w_jump && (r_ir[3:0] == 4'h0)) begin
            w_next_pc    = r_pc;
            w_next_req   = 1'b0;
            w_next_state = S_HALT;
          end
`endif
        end
      end
      S_HALT: begin
        w_next_req = 1'b0;
      end
      default: begin
        w_next_state = S_FETCH;
        w_next_req   = 1'b0;
      end
    endcase
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[7:4];
  assign ra          = r_ir[3:2];
  assign rb          = r_ir[1:0];
  assign imm         = r_ir[3:0];
  assign instr_valid = (r_state == S_ISSUE);
`ifdef FETCH_SEQUENCER_HALT_DETECT_EN
  assign halted      = (r_state == S_HALT);
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Build with FETCH_SEQUENCER_HALT_DETECT_EN to cover the halt feature.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [3:0] opcode;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] imm;
  logic       instr_valid;
  logic       stall;
  logic       b_mx;
  logic       j_mx;
  logic       reg_zero;
  logic [7:0] branch_target;
  logic [7:0] pc;
  logic       halted;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.PC_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_data(imem_data),
    .opcode(opcode),
    .ra(ra),
    .rb(rb),
    .imm(imm),
    .instr_valid(instr_valid),
    .stall(stall),
    .b_mx(b_mx),
    .j_mx(j_mx),
    .reg_zero(reg_zero),
    .branch_target(branch_target),
    .pc(pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req;
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) tick();
    if (imem_req !== 1'b1) chk("req_timeout", 32'(imem_req), 1);
  endtask

  // Fetch one instruction, issue it with the given decoder flags, check next pc
  task automatic run_instr(input logic [7:0] d, input logic b, input logic j,
                           input logic rz, input logic [7:0] bt,
                           input logic [7:0] exp_pc);
    wait_req();
    imem_valid = 1'b1;
    imem_data  = d;
    tick();
    imem_valid    = 1'b0;
    b_mx          = b;
    j_mx          = j;
    reg_zero      = rz;
    branch_target = bt;
    chk("iss_valid", 32'(instr_valid), 1);
    chk("iss_opcode", 32'(opcode), 32'(d[7:4]));
    chk("iss_req", 32'(imem_req), 0);
    tick();
    b_mx = 1'b0;
    j_mx = 1'b0;
    reg_zero = 1'b0;
    chk("nxt_valid", 32'(instr_valid), 0);
    chk("nxt_pc", 32'(pc), 32'(exp_pc));
    chk("nxt_addr", 32'(imem_addr), 32'(exp_pc));
    chk("nxt_req", 32'(imem_req), 1);
  endtask

  initial begin
    rst = 1'b1;
    imem_valid = 1'b0;
    imem_data = 8'h00;
    stall = 1'b0;
    b_mx = 1'b0;
    j_mx = 1'b0;
    reg_zero = 1'b0;
    branch_target = 8'h00;
    tick();
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_iv", 32'(instr_valid), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_halted", 32'(halted), 0);

    rst = 1'b0;
    tick();
    chk("req_rise", 32'(imem_req), 1);
    chk("addr0", 32'(imem_addr), 0);

    // Sequential run of 8'h84: opcode 8, ra 1, rb 0
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b1;
      imem_data  = 8'h84;
      tick();
      imem_valid = 1'b0;
      chk("seq_iv", 32'(instr_valid), 1);
      chk("seq_op", 32'(opcode), 8);
      chk("seq_ra", 32'(ra), 1);
      chk("seq_rb", 32'(rb), 0);
      tick();
      chk("seq_iv0", 32'(instr_valid), 0);
      chk("seq_pc", 32'(pc), 32'(i + 1));
    end

    run_instr(8'h84, 1'b1, 1'b0, 1'b1, 8'h10, 8'h10);
    run_instr(8'h1D, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0D);
    run_instr(8'h84, 1'b1, 1'b0, 1'b1, 8'h40, 8'h40);
    run_instr(8'h1D, 1'b1, 1'b1, 1'b0, 8'h80, 8'h41);
    run_instr(8'h84, 1'b1, 1'b0, 1'b1, 8'h02, 8'h02);
    run_instr(8'h0C, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFE);
    run_instr(8'hA7, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
    run_instr(8'h84, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Memory withholds valid: request and address hold, IR unchanged
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", 32'(imem_addr), 0);
      chk("wait_iv", 32'(instr_valid), 0);
      chk("wait_op", 32'(opcode), 8);
    end

    imem_valid = 1'b1;
    imem_data  = 8'h5B;
    tick();
    imem_data = 8'hFF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_iv", 32'(instr_valid), 1);
      chk("stall_pc", 32'(pc), 0);
      chk("stall_op", 32'(opcode), 5);
      chk("stall_req", 32'(imem_req), 0);
    end
    stall = 1'b0;
    imem_valid = 1'b0;
    b_mx = 1'b1;
    reg_zero = 1'b1;
    branch_target = 8'h22;
    tick();
    b_mx = 1'b0;
    reg_zero = 1'b0;
    chk("rel_pc", 32'(pc), 32'h22);
    chk("rel_iv", 32'(instr_valid), 0);
    chk("rel_req", 32'(imem_req), 1);

    // Reset during a stalled issue, with a pending valid
    imem_valid = 1'b1;
    imem_data  = 8'h84;
    tick();
    imem_valid = 1'b0;
    stall = 1'b1;
    tick();
    tick();
    chk("pre_rst_pc", 32'(pc), 32'h22);
    chk("pre_rst_iv", 32'(instr_valid), 1);
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_data = 8'hC3;
    tick();
    rst = 1'b0;
    imem_valid = 1'b0;
    stall = 1'b0;
    chk("mrst_pc", 32'(pc), 0);
    chk("mrst_op", 32'(opcode), 0);
    chk("mrst_iv", 32'(instr_valid), 0);
    chk("mrst_req", 32'(imem_req), 0);
    tick();
    chk("mrst_req1", 32'(imem_req), 1);
    chk("mrst_addr", 32'(imem_addr), 0);

    // Jump-to-self
    imem_valid = 1'b1;
    imem_data  = 8'h10;
    tick();
    imem_valid = 1'b0;
    j_mx = 1'b1;
    chk("self_iv", 32'(instr_valid), 1);
    tick();
    j_mx = 1'b0;
`ifdef FETCH_SEQUENCER_HALT_DETECT_EN
    imem_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", 32'(halted), 1);
      chk("halt_req", 32'(imem_req), 0);
      chk("halt_iv", 32'(instr_valid), 0);
      chk("halt_pc", 32'(pc), 0);
      tick();
    end
    imem_valid = 1'b0;
`else
    chk("self_halted", 32'(halted), 0);
    chk("self_req", 32'(imem_req), 1);
    chk("self_addr", 32'(imem_addr), 0);
    run_instr(8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("self_halted2", 32'(halted), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
